// File: rtl/pe_seq_ctrl_pkg.sv
// Shared types for the PE_POOL_top input sequencer: packet layout, PE marker
// states and the sequencer's own state encoding.
package pe_seq_ctrl_pkg;

    localparam int KERNEL_SIZE = 9;
    localparam int POOL_WIN    = 4;
    localparam int LANES       = 4;
    localparam int DATA_W      = 8;
    localparam int CNT_W       = 8;
    localparam int ADDR_W      = 4;
    localparam int CONV_W      = $clog2(POOL_WIN + 1);

    typedef enum logic [1:0] {
        INVALID  = 2'd0,
        VALID    = 2'd1,
        CNN_FIN  = 2'd2,
        POOL_FIN = 2'd3
    } PE_STATE;

    typedef struct packed {
        PE_STATE                       PE_state;
        logic [LANES-1:0][DATA_W-1:0]  A;
        logic [DATA_W-1:0]             wrb_data;
        logic [ADDR_W-1:0]             wrb_addr;
        logic [LANES-1:0]              wrb;
        logic [ADDR_W-1:0]             rdb_addr;
    } PE_IN_PACKET;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        POOL   = 3'd3,
        DONE   = 3'd4
    } SEQ_STATE;

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Bundle of configuration, weight/activation handshakes and PE packet output.
// master = fetch/config side, slave = the sequencer.
interface pe_seq_ctrl_if;
    import pe_seq_ctrl_pkg::*;

    logic                    cfg_start;
    logic [CNT_W-1:0]        cfg_num_windows;
    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_W-1:0]       w_data;
    logic [LANES-1:0]        w_lane_mask;
    logic                    act_valid;
    logic                    act_ready;
    logic [LANES*DATA_W-1:0] act_data;
    PE_IN_PACKET             pe_in_pk;
    logic                    busy;
    logic                    done;

    modport master (
        output cfg_start, cfg_num_windows,
        output w_valid, w_data, w_lane_mask,
        output act_valid, act_data,
        input  w_ready, act_ready, pe_in_pk, busy, done
    );

    modport slave (
        input  cfg_start, cfg_num_windows,
        input  w_valid, w_data, w_lane_mask,
        input  act_valid, act_data,
        output w_ready, act_ready, pe_in_pk, busy, done
    );

endinterface

// File: rtl/pe_seq_beat_cnt.sv
// Beat index within a kernel; shared by the weight load and the convolution stream.
module pe_seq_beat_cnt #(
    parameter int KERNEL_SIZE = 9,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_SIZE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencer driving PE_POOL_top: loads kernel weights, streams convolution
// windows with VALID/CNN_FIN markers and closes each pool window with POOL_FIN.
//
// state  | meaning
// IDLE   | waiting for cfg_start
// LOAD_W | accepting KERNEL_SIZE weight beats into the PE buffers
// STREAM | accepting activation beats, one convolution per KERNEL_SIZE beats
// POOL   | single POOL_FIN cycle after POOL_WIN convolutions
// DONE   | one-cycle end of job, done pulse follows
module pe_seq_ctrl
    import pe_seq_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    pe_seq_ctrl_if.slave  bus
);

    localparam logic [CONV_W-1:0] POOL_WIN_C = CONV_W'(POOL_WIN);

    SEQ_STATE          state_q, state_d;
    logic [CONV_W-1:0] conv_cnt_q, conv_cnt_d;
    logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]  num_win_q, num_win_d;
    PE_IN_PACKET       pk_q, pk_d;
    logic              done_q, done_d;

    logic              beat_inc, beat_clr, beat_tc;
    logic [ADDR_W-1:0] beat_cnt;

    pe_seq_beat_cnt #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .CNT_W       (ADDR_W)
    ) u_beat_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (beat_clr),
        .inc_i (beat_inc),
        .cnt_o (beat_cnt),
        .tc_o  (beat_tc)
    );

    assign bus.w_ready   = (state_q == LOAD_W);
    assign bus.act_ready = (state_q == STREAM);
    assign bus.busy      = (state_q != IDLE);
    assign bus.pe_in_pk  = pk_q;
    assign bus.done      = done_q;

    always_comb begin
        state_d     = state_q;
        conv_cnt_d  = conv_cnt_q;
        win_cnt_d   = win_cnt_q;
        num_win_d   = num_win_q;
        pk_d        = '0;
        pk_d.PE_state = INVALID;
        done_d      = 1'b0;
        beat_inc    = 1'b0;
        beat_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                beat_clr = 1'b1;
                if (bus.cfg_start) begin
                    if (bus.cfg_num_windows != '0) begin
                        num_win_d  = bus.cfg_num_windows;
                        win_cnt_d  = '0;
                        conv_cnt_d = '0;
                        state_d    = LOAD_W;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD_W: begin
                if (bus.w_valid) begin
                    pk_d.wrb_data = bus.w_data;
                    pk_d.wrb_addr = beat_cnt;
                    pk_d.wrb      = bus.w_lane_mask;
                    beat_inc      = 1'b1;
                    if (beat_tc) begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (bus.act_valid) begin
                    pk_d.A        = bus.act_data;
                    pk_d.rdb_addr = beat_cnt;
                    pk_d.PE_state = beat_tc ? CNN_FIN : VALID;
                    beat_inc      = 1'b1;
                    if (beat_tc) begin
                        conv_cnt_d = conv_cnt_q + CONV_W'(1);
                        if (conv_cnt_d == POOL_WIN_C) begin
                            state_d = POOL;
                        end
                    end
                end
            end
            POOL: begin
                pk_d.PE_state = POOL_FIN;
                conv_cnt_d    = '0;
                win_cnt_d     = win_cnt_q + CNT_W'(1);
                state_d       = (win_cnt_d == num_win_q) ? DONE : STREAM;
            end
            DONE: begin
                done_d   = 1'b1;
                beat_clr = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            conv_cnt_q <= '0;
            win_cnt_q  <= '0;
            num_win_q  <= '0;
            pk_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            win_cnt_q  <= win_cnt_d;
            num_win_q  <= num_win_d;
            pk_q       <= pk_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl: each job's full expected packet sequence is
// derived from the job description and checked by an independent monitor.
module tb_pe_seq_ctrl;
    import pe_seq_ctrl_pkg::*;

    localparam int K_LOAD   = 0;
    localparam int K_STREAM = 1;
    localparam int K_POOL   = 2;
    localparam int K_DONE   = 3;

    typedef struct {
        int          kind;
        PE_IN_PACKET pk;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    pe_seq_ctrl_if bus();

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   done_seen = 1'b0;

    always #5 clk = ~clk;

    pe_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Blank out the fields a packet of this kind leaves undefined.
    function automatic PE_IN_PACKET care(input PE_IN_PACKET p, input int kind);
        PE_IN_PACKET r;
        r = p;
        case (kind)
            K_LOAD:   r.rdb_addr = '0;
            K_STREAM: r.wrb_addr = '0;
            K_POOL:   begin r.wrb_addr = '0; r.wrb_data = '0; end
            default:  r = p;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            PE_IN_PACKET got;
            exp_t        e;
            got = bus.pe_in_pk;
            if (got.PE_state != INVALID || got.wrb != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_packet", 64'(got), 64'(0));
                end else begin
                    e = sb.pop_front();
                    if (e.kind == K_DONE) begin
                        chk("packet_vs_done", 64'(got), 64'(0));
                        sb.push_front(e);
                    end else begin
                        chk("packet", 64'(care(got, e.kind)), 64'(care(e.pk, e.kind)));
                    end
                end
            end else begin
                chk("bubble", {got.A, got.rdb_addr}, '0);
            end
            if (bus.done) begin
                done_seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("done_order", 64'(e.kind), 64'(K_DONE));
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.cfg_start       = 1'b0;
        bus.cfg_num_windows = '0;
        bus.w_valid         = 1'b0;
        bus.w_data          = '0;
        bus.w_lane_mask     = '0;
        bus.act_valid       = 1'b0;
        bus.act_data        = '0;
    endtask

    task automatic zero_job();
        exp_t e;
        e.kind = K_DONE;
        e.pk   = '0;
        sb.push_back(e);
        @(negedge clk); #1;
        bus.cfg_start       = 1'b1;
        bus.cfg_num_windows = '0;
        @(negedge clk); #1;
        bus.cfg_start = 1'b0;
        chk("zero_done_early", 64'(bus.done), 64'(0));
        chk("zero_busy", 64'(bus.busy), 64'(1));
        @(negedge clk); #1;
        chk("zero_done_pulse", 64'(bus.done), 64'(1));
        @(negedge clk); #1;
        chk("zero_done_width", 64'(bus.done), 64'(0));
        chk("zero_sb_empty", 64'(sb.size()), 64'(0));
    endtask

    task automatic run_job(input int n, input bit directed, input int prob,
                           input int stall_at, input int abort_at, input int extra_at);
        logic [DATA_W-1:0]       w[KERNEL_SIZE];
        logic [LANES-1:0]        m[KERNEL_SIZE];
        logic [LANES*DATA_W-1:0] a[$];
        exp_t e;
        int   wi, ai, total, stall_cnt;
        bit   hs_w, hs_a, finished, extra_done;

        for (int k = 0; k < KERNEL_SIZE; k++) begin
            w[k] = directed ? DATA_W'(k + 1) : DATA_W'($urandom);
            m[k] = directed ? 4'hF : LANES'($urandom_range(1, 15));
            e.kind = K_LOAD;
            e.pk = '0;
            e.pk.wrb_data = w[k];
            e.pk.wrb_addr = ADDR_W'(k);
            e.pk.wrb      = m[k];
            sb.push_back(e);
        end
        for (int win = 0; win < n; win++) begin
            for (int c = 0; c < POOL_WIN; c++) begin
                for (int b = 0; b < KERNEL_SIZE; b++) begin
                    logic [LANES*DATA_W-1:0] v;
                    v = directed ? {8'(8'h30 + b), 8'(8'h20 + b), 8'(8'h10 + b), 8'(b)} : $urandom;
                    a.push_back(v);
                    e.kind = K_STREAM;
                    e.pk = '0;
                    e.pk.A = v;
                    e.pk.rdb_addr = ADDR_W'(b);
                    e.pk.PE_state = (b == KERNEL_SIZE - 1) ? CNN_FIN : VALID;
                    sb.push_back(e);
                end
            end
            e.kind = K_POOL;
            e.pk = '0;
            e.pk.PE_state = POOL_FIN;
            sb.push_back(e);
        end
        e.kind = K_DONE;
        e.pk = '0;
        sb.push_back(e);
        total = a.size();

        done_seen = 1'b0;
        @(negedge clk); #1;
        bus.cfg_start       = 1'b1;
        bus.cfg_num_windows = CNT_W'(n);
        @(negedge clk); #1;
        bus.cfg_start = 1'b0;
        chk("start_busy", 64'(bus.busy), 64'(1));
        chk("start_w_ready", 64'({bus.w_ready, bus.act_ready}), 64'(2'b10));

        wi = 0; ai = 0; stall_cnt = 0;
        hs_w = 0; hs_a = 0; finished = 0; extra_done = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (hs_w) wi++;
            if (hs_a) ai++;
            hs_w = 0;
            hs_a = 0;
            if (done_seen) begin
                finished = 1;
                break;
            end
            if (abort_at >= 0 && ai == abort_at) begin
                idle_inputs();
                reset = 1'b1;
                @(posedge clk); #1;
                sb.delete();
                @(negedge clk); #1;
                reset = 1'b0;
                chk("abort_packet", 64'(bus.pe_in_pk), 64'(0));
                chk("abort_busy_done", 64'({bus.busy, bus.done}), 64'(0));
                repeat (12) @(negedge clk);
                #1;
                chk("abort_no_done", 64'(done_seen), 64'(0));
                finished = 1;
                break;
            end
            bus.cfg_start = 1'b0;
            if (extra_at >= 0 && ai == extra_at && !extra_done) begin
                bus.cfg_start       = 1'b1;
                bus.cfg_num_windows = CNT_W'(7);
                extra_done = 1;
            end
            bus.w_valid = (wi < KERNEL_SIZE) && ($urandom_range(0, 99) < prob);
            if (wi < KERNEL_SIZE) begin
                bus.w_data      = w[wi];
                bus.w_lane_mask = m[wi];
            end
            bus.act_valid = (ai < total) && ($urandom_range(0, 99) < prob);
            if (ai == stall_at && stall_cnt < 3 && bus.act_ready) begin
                bus.act_valid = 1'b0;
                stall_cnt++;
            end
            if (ai < total) bus.act_data = a[ai];
            hs_w = bus.w_valid && bus.w_ready;
            hs_a = bus.act_valid && bus.act_ready;
            @(negedge clk); #1;
        end
        idle_inputs();
        chk("job_finished", 64'(finished), 64'(1));
        chk("sb_drained", 64'(sb.size()), 64'(0));
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            chk("reset_packet", 64'(bus.pe_in_pk), 64'(0));
            chk("reset_flags", 64'({bus.busy, bus.done, bus.w_ready, bus.act_ready}), 64'(0));
        end

        run_job(1, 1'b1, 100, -1, -1, -1);
        run_job(1, 1'b1, 100, 4, -1, -1);
        zero_job();
        run_job(2, 1'b0, 100, -1, KERNEL_SIZE + 4, -1);
        run_job(2, 1'b0, 80, -1, -1, 20);
        repeat (4) run_job($urandom_range(1, 3), 1'b0, 60, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
